mips_multi: RTL and testbench
=============================

# mips_multi

Multi-cycle MIPS processor core: the parametrised successor to the single-cycle core. It executes one instruction over 3–5 states of a control FSM, sharing a single ALU and a single external memory port for both instructions and data. The memory port uses a request/ready handshake, so instruction and data memories of any latency can be attached. The block contains its own 32×32 register file and adds a halt-on-illegal-instruction mode, a retirement strobe and a configurable reset vector.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  Core clock; all state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- mem_req  out  1  Memory transaction request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  32  Byte address; bits [1:0] are passed through unchanged and not checked.
- mem_wdata  out  32  Store data (register B); valid when mem_we is high.
- mem_rdata  in  32  Read data; sampled on the edge where mem_req and mem_ready are both high.
- mem_ready  in  1  Transaction completes on the clock edge where mem_req and mem_ready are both high.
- pc  out  32  Current PC register.
- retire  out  1  One-cycle pulse in the last state of each completed instruction.
- halted  out  1  High while in the HALT state.

## Operation
- Registers: PC, IR, MDR, A, B, ALUOut, a 32×32 register file, and the FSM state.
- Register $0 reads as 0; writes to $0 are discarded.
- Supported instructions:
  - R-type (opcode 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A. slt is a signed compare.
  - lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08.
  - addi has no overflow trap; add and sub wrap modulo 2^32.
- Instruction word 32'h0000_0000 is a NOP: it follows the R-type path, and its RWB state performs no write.
- Any other opcode, or any other R-type funct, goes to HALT. A halted instruction does not retire.
- FSM states: FETCH, DECODE, EXEC, MEM, MWB, RWB, HALT.
- FETCH:
  - Outputs: mem_req=1, mem_we=0, mem_addr=PC.
  - On the ready edge: IR<=mem_rdata, PC<=PC+4, go to DECODE.
- DECODE:
  - A<=RF[rs], B<=RF[rt].
  - ALUOut<=PC+(sext(imm)<<2), the branch target.
  - Illegal opcode or funct goes to HALT; otherwise go to EXEC.
- EXEC:
  - R-type: ALUOut<=A op B, go to RWB.
  - lw/sw: ALUOut<=A+sext(imm), go to MEM.
  - addi: ALUOut<=A+sext(imm), go to RWB; the write target is rt.
  - beq: if A==B then PC<=ALUOut. Retire, go to FETCH.
  - j: PC<={PC[31:28], IR[25:0], 2'b00}. Retire, go to FETCH.
- MEM:
  - Outputs: mem_req=1, mem_addr=ALUOut, mem_we=(sw), mem_wdata=B.
  - On the ready edge, sw retires and goes to FETCH.
  - On the ready edge, lw does MDR<=mem_rdata and goes to MWB.
- MWB: RF[rt]<=MDR. Retire, go to FETCH.
- RWB: write ALUOut to RF[rd] (R-type) or RF[rt] (addi). Retire, go to FETCH.
- HALT:
  - Absorbing state: mem_req=0 and halted=1.
  - Only rst exits HALT.

## Timing
- Reset (sampled on a clock edge):
  - Next state is FETCH, PC<=RESET_PC.
  - IR, MDR, A, B and ALUOut are cleared to 0.
  - All 32 register-file entries are cleared to 0.
  - During the reset cycle and the state after it: mem_req=0, mem_we=0, retire=0, halted=0.
  - Reset during any state, including a mem_req wait, abandons the transaction. mem_req is low in the cycle after the reset edge.
- Handshake rules:
  - Once mem_req is raised, mem_req, mem_we, mem_addr and mem_wdata stay stable until the ready edge.
  - mem_req falls in the cycle after the ready edge, because the state changes.
  - mem_ready is ignored while mem_req is low.
  - There is no limit on wait cycles.
- Cycle counts with mem_ready tied high (each memory wait cycle adds one):
  - beq, j: 3 cycles.
  - R-type, addi, sw, NOP: 4 cycles.
  - lw: 5 cycles.
- Output timing:
  - retire is asserted combinationally in the final state and deasserts the next cycle.
  - pc reflects the registered PC; it updates on the FETCH ready edge and on a taken beq or a j.
- A register-file write and a read in the following DECODE see the new value, because the write completes at the edge.

## Test plan
- Reset vector:
  - Stimulus: RESET_PC=32'h0000_0100, mem_ready=1, memory at 0x100 holds addi $1,$0,5.
  - Required response: first mem_addr=0x100; retire at cycle 4; RF[1]=5; pc=0x104.
- Arithmetic program:
  - Stimulus: addi $1,$0,-3; addi $2,$0,7; add $3,$1,$2; sub $4,$1,$2; slt $5,$1,$2; and/or.
  - Required response: $3=4, $4=0xFFFF_FFF6, $5=1; five retire pulses for the first five instructions.
- Memory with waits:
  - Stimulus: sw $2,8($0) then lw $6,8($0), with mem_ready delayed 3 cycles on every request.
  - Required response: mem_addr/mem_wdata stay stable for 4 cycles; the write is 7 at address 8; $6=7; lw takes 5+6 cycles.
- Control flow:
  - Stimulus: beq $1,$1,+2 at 0x00.
  - Required response: next fetch at 0x0C.
  - Stimulus: beq not taken.
  - Required response: fetch at 0x04.
  - Stimulus: j 0x40 (target 0x100).
  - Required response: pc=0x100; each takes 3 cycles.
- Illegal instruction:
  - Stimulus: opcode 0x3F.
  - Required response: halted=1 from the cycle after DECODE, no retire, mem_req stays 0 for 20 cycles; rst returns to FETCH at RESET_PC.
- Reset mid-transaction:
  - Stimulus: assert rst while in MEM with mem_ready=0.
  - Required response: mem_req=0 next cycle; RF all 0; fetch restarts at RESET_PC; no write occurs.

Source files
------------

// File: rtl/mips_multi.sv
// Multi-cycle MIPS core: shared ALU, single request/ready memory port, 32x32 register file.
// Latency: beq/j 3 cycles, R-type/addi/sw/NOP 4, lw 5, plus one per memory wait cycle.
// Backpressure: FETCH/MEM hold request, address and data stable until mem_ready; no wait limit.
// Ports: clk, rst (sync, active-high); mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ready in;
//        pc (registered PC), retire (pulse in final state), halted (high in HALT).
module mips_multi #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, MWB, RWB, HALT} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
  logic [31:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d;
  logic        boot_q, boot_d;
  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  logic        is_r, is_nop, is_lw, is_sw, is_beq, is_j, is_addi, funct_ok, legal;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign is_r     = (opcode == 6'h00);
  assign is_nop   = (ir_q == 32'h0);
  assign is_lw    = (opcode == 6'h23);
  assign is_sw    = (opcode == 6'h2B);
  assign is_beq   = (opcode == 6'h04);
  assign is_j     = (opcode == 6'h02);
  assign is_addi  = (opcode == 6'h08);
  assign funct_ok = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                    (funct == 6'h25) || (funct == 6'h2A);
  // The all-zero word has funct 0, so it is admitted explicitly as the NOP.
  assign legal    = (is_r && (funct_ok || is_nop)) || is_lw || is_sw || is_beq || is_j || is_addi;

  // Single shared ALU; operands are steered by the current state.
  logic [31:0] alu_a, alu_b, alu_y;
  alu_op_t     alu_op;

  always_comb begin
    alu_a  = pc_q;
    alu_b  = 32'd4;
    alu_op = ALU_ADD;
    case (state_q)
      DECODE: alu_b = {imm_sext[29:0], 2'b00};   // branch target off PC+4
      EXEC: begin
        alu_a = a_q;
        if (is_r) begin
          alu_b = b_q;
          case (funct)
            6'h22:   alu_op = ALU_SUB;
            6'h24:   alu_op = ALU_AND;
            6'h25:   alu_op = ALU_OR;
            6'h2A:   alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
          endcase
        end else begin
          alu_b = imm_sext;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_y = 32'h0;
    case (alu_op)
      ALU_ADD: alu_y = alu_a + alu_b;
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = 32'h0;
    endcase
  end

  // Memory port. boot_q masks the request in the first cycle after reset so
  // the port is guaranteed idle then, even though the state is already FETCH.
  logic xfer;
  assign mem_req   = !rst && !boot_q && ((state_q == FETCH) || (state_q == MEM));
  assign mem_we    = mem_req && (state_q == MEM) && is_sw;
  assign mem_addr  = (state_q == MEM) ? alu_out_q : pc_q;
  assign mem_wdata = b_q;
  assign xfer      = mem_req && mem_ready;
  assign pc        = pc_q;
  assign halted    = !rst && (state_q == HALT);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    boot_d    = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = alu_out_q;
    retire    = 1'b0;
    case (state_q)
      FETCH: if (xfer) begin
        ir_d    = mem_rdata;
        pc_d    = alu_y;
        state_d = DECODE;
      end
      DECODE: begin
        a_d       = rf_q[rs];
        b_d       = rf_q[rt];
        alu_out_d = alu_y;
        state_d   = legal ? EXEC : HALT;
      end
      EXEC: begin
        if (is_r || is_addi) begin
          alu_out_d = alu_y;
          state_d   = RWB;
        end else if (is_lw || is_sw) begin
          alu_out_d = alu_y;
          state_d   = MEM;
        end else if (is_beq) begin
          if (a_q == b_q) pc_d = alu_out_q;
          retire  = 1'b1;
          state_d = FETCH;
        end else if (is_j) begin
          pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
          retire  = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = HALT;
        end
      end
      MEM: if (xfer) begin
        if (is_sw) begin
          retire  = 1'b1;
          state_d = FETCH;
        end else begin
          mdr_d   = mem_rdata;
          state_d = MWB;
        end
      end
      MWB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      RWB: begin
        rf_we    = !is_nop;
        rf_waddr = is_addi ? rt : rd;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = HALT;
    endcase
    if (rst) retire = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      boot_q    <= 1'b1;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      boot_q    <= boot_d;
      // $0 is never written, so it keeps reading as zero.
      if (rf_we && (rf_waddr != 5'd0)) rf_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mips_multi.sv
// Directed bench for mips_multi: small program per scenario, memory with programmable latency.
module tb_mips_multi;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  int n_cmp = 0;
  int n_bad = 0;

  // Program region (written by the stimulus) and data region below 0x100 (written by the DUT).
  logic [31:0] prog [0:255];
  logic [31:0] dmem [0:63] = '{default: 32'h0};
  int          lat = 0;
  bit          block_we = 1'b0;
  int          cnt = 0;
  int          wr_count = 0;
  logic [31:0] wr_addr = '0, wr_data = '0;

  mips_multi #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr[31:8] == 24'h0) ? dmem[mem_addr[7:2]] : prog[mem_addr[9:2]];
  assign mem_ready = mem_req && !(block_we && mem_we) && (cnt >= lat);

  always @(posedge clk) begin
    if (mem_req && mem_ready) begin
      cnt <= 0;
      if (mem_we) begin
        dmem[mem_addr[7:2]] <= mem_wdata;
        wr_count <= wr_count + 1;
        wr_addr  <= mem_addr;
        wr_data  <= mem_wdata;
      end
    end else if (mem_req) cnt <= cnt + 1;
    else cnt <= 0;
  end

  task clear_prog;
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
  endtask

  task put(input logic [31:0] addr, input logic [31:0] w);
    prog[addr[9:2]] = w;
  endtask

  // Leaves the bench at the negedge of cycle 0 (first cycle after the reset edge).
  task do_reset;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
  endtask

  // Index (from the current cycle = 0) of the n-th retire pulse; -1 if the budget expires.
  // Returns at the negedge of the cycle after that pulse.
  task wait_retires(input int n, input int budget, output int at);
    int seen;
    seen = 0; at = -1;
    for (int c = 0; c < budget; c++) begin
      if (retire) begin
        seen++;
        if (seen == n) begin at = c; break; end
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task test_reset;
    int nz;
    clear_prog; put(RPC, 32'h2001_0005); lat = 0;
    @(negedge clk); rst = 1'b1; #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_cycle_req: got %b want 0", mem_req); end
    n_cmp++; if ({retire, halted} !== 2'b00) begin n_bad++; $display("FAIL rst_cycle_ret_halt: got %b want 00", {retire, halted}); end
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++; if ({mem_req, mem_we, retire, halted} !== 4'b0000) begin n_bad++; $display("FAIL post_rst_outs: got %b want 0000", {mem_req, mem_we, retire, halted}); end
    n_cmp++; if (pc !== RPC) begin n_bad++; $display("FAIL post_rst_pc: got %h want %h", pc, RPC); end
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.rf_q[i] !== 32'h0) nz++;
    n_cmp++; if (nz !== 0) begin n_bad++; $display("FAIL post_rst_rf: got %0d nonzero want 0", nz); end
  endtask

  task test_reset_vector;
    int at;
    clear_prog; put(RPC, 32'h2001_0005); lat = 0;   // addi $1,$0,5
    do_reset;
    @(negedge clk);
    n_cmp++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h100) begin n_bad++; $display("FAIL rv_first_fetch: got req/we %b addr %h want 10 / 00000100", {mem_req, mem_we}, mem_addr); end
    wait_retires(1, 20, at);
    n_cmp++; if (at + 1 !== 4) begin n_bad++; $display("FAIL rv_retire_cycle: got %0d want 4", at + 1); end
    n_cmp++; if (dut.rf_q[1] !== 32'd5) begin n_bad++; $display("FAIL rv_rf1: got %h want 5", dut.rf_q[1]); end
    n_cmp++; if (pc !== 32'h104) begin n_bad++; $display("FAIL rv_pc: got %h want 104", pc); end
  endtask

  task test_arith;
    int at;
    logic [31:0] exp_rf [1:7];
    clear_prog; lat = 0;
    put(32'h100, 32'h2001_FFFD);  // addi $1,$0,-3
    put(32'h104, 32'h2002_0007);  // addi $2,$0,7
    put(32'h108, 32'h0022_1820);  // add  $3,$1,$2
    put(32'h10C, 32'h0022_2022);  // sub  $4,$1,$2
    put(32'h110, 32'h0022_282A);  // slt  $5,$1,$2
    put(32'h114, 32'h0022_3024);  // and  $6,$1,$2
    put(32'h118, 32'h0022_3825);  // or   $7,$1,$2
    exp_rf[1] = 32'hFFFF_FFFD; exp_rf[2] = 32'd7; exp_rf[3] = 32'd4; exp_rf[4] = 32'hFFFF_FFF6;
    exp_rf[5] = 32'd1; exp_rf[6] = 32'd5; exp_rf[7] = 32'hFFFF_FFFF;
    do_reset;
    wait_retires(5, 60, at);
    n_cmp++; if (at !== 20) begin n_bad++; $display("FAIL arith_5th_retire: got cycle %0d want 20", at); end
    wait_retires(2, 30, at);
    n_cmp++; if (at !== 7) begin n_bad++; $display("FAIL arith_7th_retire: got %0d want 7", at); end
    for (int r = 1; r <= 7; r++) begin
      n_cmp++; if (dut.rf_q[r] !== exp_rf[r]) begin n_bad++; $display("FAIL arith_rf%0d: got %h want %h", r, dut.rf_q[r], exp_rf[r]); end
    end
  endtask

  task test_mem_waits;
    int at, held, unstable, wr0;
    clear_prog; lat = 3;
    put(32'h100, 32'h2002_0007);  // addi $2,$0,7
    put(32'h104, 32'hAC02_0008);  // sw   $2,8($0)
    put(32'h108, 32'h8C06_0008);  // lw   $6,8($0)
    do_reset;
    wait_retires(1, 40, at);
    n_cmp++; if (at !== 7) begin n_bad++; $display("FAIL mw_addi_cycles: got %0d want 7", at); end
    wr0 = wr_count; held = 0; unstable = 0;
    for (int c = 0; c < 40; c++) begin
      if (mem_req && mem_we) begin
        held++;
        if (mem_addr !== 32'h8 || mem_wdata !== 32'd7) unstable++;
      end
      if (retire) break;
      @(negedge clk);
    end
    @(negedge clk);
    n_cmp++; if (held !== 4 || unstable !== 0) begin n_bad++; $display("FAIL mw_sw_hold: got %0d held %0d unstable want 4 held 0 unstable", held, unstable); end
    n_cmp++; if (wr_count - wr0 !== 1 || wr_addr !== 32'h8 || wr_data !== 32'd7) begin n_bad++; $display("FAIL mw_write: got n=%0d addr %h data %h want n=1 addr 8 data 7", wr_count - wr0, wr_addr, wr_data); end
    wait_retires(1, 40, at);
    n_cmp++; if (at + 1 !== 11) begin n_bad++; $display("FAIL mw_lw_cycles: got %0d want 11", at + 1); end
    n_cmp++; if (dut.rf_q[6] !== 32'd7) begin n_bad++; $display("FAIL mw_lw_rf6: got %h want 7", dut.rf_q[6]); end
    lat = 0;
  endtask

  task test_control;
    int at;
    clear_prog; lat = 0;
    put(32'h100, 32'h2001_0001);  // addi $1,$0,1
    put(32'h104, 32'h1021_0002);  // beq  $1,$1,+2  -> 0x110
    put(32'h110, 32'h1020_0002);  // beq  $1,$0,+2  not taken
    put(32'h114, 32'h0800_0040);  // j    0x40 -> 0x100
    do_reset;
    wait_retires(1, 20, at);
    wait_retires(1, 20, at);
    n_cmp++; if (at + 1 !== 3) begin n_bad++; $display("FAIL beq_taken_cycles: got %0d want 3", at + 1); end
    n_cmp++; if (!mem_req || mem_addr !== 32'h110 || pc !== 32'h110) begin n_bad++; $display("FAIL beq_taken_fetch: got req %b addr %h pc %h want 1 110 110", mem_req, mem_addr, pc); end
    wait_retires(1, 20, at);
    n_cmp++; if (at + 1 !== 3) begin n_bad++; $display("FAIL beq_nt_cycles: got %0d want 3", at + 1); end
    n_cmp++; if (!mem_req || mem_addr !== 32'h114) begin n_bad++; $display("FAIL beq_nt_fetch: got req %b addr %h want 1 114", mem_req, mem_addr); end
    wait_retires(1, 20, at);
    n_cmp++; if (at + 1 !== 3) begin n_bad++; $display("FAIL j_cycles: got %0d want 3", at + 1); end
    n_cmp++; if (pc !== 32'h100 || mem_addr !== 32'h100) begin n_bad++; $display("FAIL j_target: got pc %h addr %h want 100 100", pc, mem_addr); end
  endtask

  task test_illegal;
    int rets, reqs, not_halted;
    clear_prog; lat = 0;
    put(RPC, 32'hFC00_0000);        // opcode 0x3F
    do_reset;
    rets = 0; reqs = 0; not_halted = 0;
    for (int c = 0; c < 25; c++) begin
      if (retire) rets++;
      if (c == 2) begin
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL ill_decode_halted: got %b want 0", halted); end
      end
      if (c >= 3) begin
        if (mem_req !== 1'b0) reqs++;
        if (halted !== 1'b1) not_halted++;
      end
      @(negedge clk);
    end
    n_cmp++; if (rets !== 0) begin n_bad++; $display("FAIL ill_retire: got %0d want 0", rets); end
    n_cmp++; if (reqs !== 0 || not_halted !== 0) begin n_bad++; $display("FAIL ill_halt_hold: got %0d req %0d unhalted want 0 0", reqs, not_halted); end
    do_reset;
    n_cmp++; if (halted !== 1'b0 || mem_req !== 1'b0 || pc !== RPC) begin n_bad++; $display("FAIL ill_reset: got halted %b req %b pc %h want 0 0 100", halted, mem_req, pc); end
    @(negedge clk);
    n_cmp++; if (!mem_req || mem_addr !== RPC) begin n_bad++; $display("FAIL ill_refetch: got req %b addr %h want 1 100", mem_req, mem_addr); end
  endtask

  task test_reset_mid;
    int at, nz, wr0;
    bit found;
    clear_prog; lat = 0;
    put(32'h100, 32'h2001_0005);  // addi $1,$0,5
    put(32'h104, 32'hAC01_0020);  // sw   $1,0x20($0)
    block_we = 1'b1;
    do_reset;
    wait_retires(1, 20, at);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (mem_req && mem_we) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL rm_reach_mem: got %b want 1", found); end
    repeat (3) @(negedge clk);
    wr0 = wr_count;
    rst = 1'b1; #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rm_req_in_rst: got %b want 0", mem_req); end
    @(negedge clk); rst = 1'b0; block_we = 1'b0; #1;
    n_cmp++; if (mem_req !== 1'b0 || pc !== RPC) begin n_bad++; $display("FAIL rm_after: got req %b pc %h want 0 100", mem_req, pc); end
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.rf_q[i] !== 32'h0) nz++;
    n_cmp++; if (nz !== 0) begin n_bad++; $display("FAIL rm_rf_clear: got %0d nonzero want 0", nz); end
    n_cmp++; if (wr_count !== wr0) begin n_bad++; $display("FAIL rm_no_write: got %0d writes want 0", wr_count - wr0); end
    @(negedge clk);
    n_cmp++; if (!mem_req || mem_we || mem_addr !== RPC) begin n_bad++; $display("FAIL rm_refetch: got req %b we %b addr %h want 1 0 100", mem_req, mem_we, mem_addr); end
  endtask

  initial begin
    test_reset;
    test_reset_vector;
    test_arith;
    test_mem_waits;
    test_control;
    test_illegal;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
